// File: rtl/pulse_period_meter.sv
// Measures the spacing between rising edges of a pulse train in STEP units per clock,
// producing the compare value that lets the step-counting divider regenerate the same rate.
module pulse_period_meter #(
    parameter int unsigned STEP      = 4,
    parameter logic [31:0] MAX_COUNT = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        pulse_in,
    output logic [31:0] period_out,
    output logic        period_strobe,
    output logic        period_valid,
    output logic        timeout
);

    localparam logic [31:0] STEP_W = 32'(STEP);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t      state, state_nx;
    logic [31:0] cnt, cnt_nx;
    logic [31:0] period_nx;
    logic        strobe_nx, valid_nx, timeout_nx;

    logic        sync_p0, sync_p1, prev_p2;
    logic        rise;

    // Stage boundary: two-flop synchronizer followed by the edge-history flop
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
        end else begin
            sync_p0 <= pulse_in;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;

    // Stage boundary: measurement state and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            period_out    <= '0;
            period_strobe <= 1'b0;
            period_valid  <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            period_out    <= period_nx;
            period_strobe <= strobe_nx;
            period_valid  <= valid_nx;
            timeout       <= timeout_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        period_nx  = period_out;
        strobe_nx  = 1'b0;
        valid_nx   = period_valid;
        timeout_nx = timeout;

        if (!enable) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            valid_nx   = 1'b0;
            timeout_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // The first edge after idle only starts the interval; nothing to report yet.
                    cnt_nx = '0;
                    if (rise) begin
                        state_nx = ARMED;
                    end
                end
                ARMED: begin
                    // An edge arriving on the same cycle as the threshold still counts as valid.
                    if (rise) begin
                        period_nx  = cnt;
                        strobe_nx  = 1'b1;
                        valid_nx   = 1'b1;
                        timeout_nx = 1'b0;
                        cnt_nx     = '0;
                    end else if (cnt >= MAX_COUNT) begin
                        timeout_nx = 1'b1;
                        valid_nx   = 1'b0;
                        state_nx   = IDLE;
                        cnt_nx     = '0;
                    end else begin
                        cnt_nx = cnt + STEP_W;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter: one instance with the default threshold and one
// with MAX_COUNT=40; strobes are scored against per-instance expected-period queues.
module tb_pulse_period_meter;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        pulse_a, pulse_b;
    logic [31:0] period_out_a, period_out_b;
    logic        period_strobe_a, period_strobe_b;
    logic        period_valid_a, period_valid_b;
    logic        timeout_a, timeout_b;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clock = ~clock;

    pulse_period_meter dut_a (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .pulse_in      (pulse_a),
        .period_out    (period_out_a),
        .period_strobe (period_strobe_a),
        .period_valid  (period_valid_a),
        .timeout       (timeout_a)
    );

    pulse_period_meter #(
        .STEP      (4),
        .MAX_COUNT (32'd40)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .pulse_in      (pulse_b),
        .period_out    (period_out_b),
        .period_strobe (period_strobe_b),
        .period_valid  (period_valid_b),
        .timeout       (timeout_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One-clock pulse, next pulse starts gap clocks later; exp_val < 0 means no strobe due.
    task automatic pa(input int gap, input int exp_val);
        @(negedge clock);
        if (exp_val >= 0) q_a.push_back(32'(exp_val));
        pulse_a = 1'b1;
        @(negedge clock);
        pulse_a = 1'b0;
        repeat (gap - 2) @(negedge clock);
    endtask

    task automatic pb(input int gap, input int exp_val);
        @(negedge clock);
        if (exp_val >= 0) q_b.push_back(32'(exp_val));
        pulse_b = 1'b1;
        @(negedge clock);
        pulse_b = 1'b0;
        repeat (gap - 2) @(negedge clock);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_period"},  period_out_a, 32'd0);
        chk({tag, "_a_strobe"},  32'(period_strobe_a), 32'd0);
        chk({tag, "_a_valid"},   32'(period_valid_a), 32'd0);
        chk({tag, "_a_timeout"}, 32'(timeout_a), 32'd0);
        chk({tag, "_b_period"},  period_out_b, 32'd0);
        chk({tag, "_b_strobe"},  32'(period_strobe_b), 32'd0);
        chk({tag, "_b_valid"},   32'(period_valid_b), 32'd0);
        chk({tag, "_b_timeout"}, 32'(timeout_b), 32'd0);
    endtask

    always @(negedge clock) begin
        if (period_strobe_a) begin
            if (q_a.size() == 0) chk("a_unexpected_strobe", 32'(period_strobe_a), 32'd0);
            else                 chk("a_strobe_period", period_out_a, q_a.pop_front());
        end
        if (period_strobe_b) begin
            if (q_b.size() == 0) chk("b_unexpected_strobe", 32'(period_strobe_b), 32'd0);
            else                 chk("b_strobe_period", period_out_b, q_b.pop_front());
        end
    end

    initial begin
        reset   = 1'b0;
        enable  = 1'b0;
        pulse_a = 1'b0;
        pulse_b = 1'b0;
        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;

        // Steady 10-clock train: first edge arms only, then 36 per strobe
        pa(10, -1);
        chk("a_valid_after_arm", 32'(period_valid_a), 32'd0);
        for (int i = 0; i < 4; i++) pa(10, 36);
        chk("a_period_10", period_out_a, 32'd36);
        chk("a_valid_10", 32'(period_valid_a), 32'd1);
        chk("a_timeout_10", 32'(timeout_a), 32'd0);

        // Spacing change to 25 clocks, with an explicit latency check
        pa(25, 36);
        @(negedge clock);
        q_a.push_back(32'd96);
        pulse_a = 1'b1;
        @(negedge clock);
        pulse_a = 1'b0;
        chk("a_lat_edge1", 32'(period_strobe_a), 32'd0);
        @(negedge clock);
        chk("a_lat_edge2", 32'(period_strobe_a), 32'd0);
        @(negedge clock);
        chk("a_lat_edge3", 32'(period_strobe_a), 32'd1);
        chk("a_lat_period", period_out_a, 32'd96);
        repeat (21) @(negedge clock);
        pa(10, 96);
        pa(10, 36);
        pa(10, 36);
        chk("a_period_back10", period_out_a, 32'd36);

        // Enable dropped for 5 clocks
        @(negedge clock);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        chk("a_dis_valid", 32'(period_valid_a), 32'd0);
        chk("a_dis_timeout", 32'(timeout_a), 32'd0);
        chk("a_dis_period", period_out_a, 32'd36);
        chk("a_dis_strobe", 32'(period_strobe_a), 32'd0);
        enable = 1'b1;
        pa(10, -1);
        chk("a_reen_valid", 32'(period_valid_a), 32'd0);
        pa(10, 36);
        chk("a_reen_period", period_out_a, 32'd36);
        chk("a_reen_valid2", 32'(period_valid_a), 32'd1);

        // Threshold boundary: 11-clock spacing lands exactly on MAX_COUNT
        pb(11, -1);
        for (int i = 0; i < 3; i++) pb(11, 40);
        chk("b_period_11", period_out_b, 32'd40);
        chk("b_valid_11", 32'(period_valid_b), 32'd1);
        chk("b_timeout_11", 32'(timeout_b), 32'd0);

        // Last 11-clock edge, then silence: timeout 11 clocks after the arming edge
        @(negedge clock);
        q_b.push_back(32'd40);
        pulse_b = 1'b1;
        @(negedge clock);
        pulse_b = 1'b0;
        repeat (12) @(negedge clock);
        chk("b_timeout_before", 32'(timeout_b), 32'd0);
        @(negedge clock);
        chk("b_timeout_set", 32'(timeout_b), 32'd1);
        chk("b_timeout_valid", 32'(period_valid_b), 32'd0);
        chk("b_timeout_period", period_out_b, 32'd40);
        pb(11, -1);
        chk("b_rearm_timeout", 32'(timeout_b), 32'd1);
        chk("b_rearm_valid", 32'(period_valid_b), 32'd0);
        pb(11, 40);
        chk("b_recover_timeout", 32'(timeout_b), 32'd0);
        chk("b_recover_valid", 32'(period_valid_b), 32'd1);
        chk("b_recover_period", period_out_b, 32'd40);

        // Timeout cleared by enable low
        repeat (14) @(negedge clock);
        chk("b_timeout_again", 32'(timeout_b), 32'd1);
        enable = 1'b0;
        @(negedge clock);
        chk("b_dis_timeout", 32'(timeout_b), 32'd0);
        chk("b_dis_valid", 32'(period_valid_b), 32'd0);
        enable = 1'b1;

        // Asynchronous reset in the middle of a count
        pa(10, -1);
        pa(10, 36);
        repeat (3) @(negedge clock);
        chk("a_pre_reset_valid", 32'(period_valid_a), 32'd1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge clock);
        reset = 1'b1;
        pa(10, -1);
        chk("a_fresh_valid", 32'(period_valid_a), 32'd0);
        pa(10, 36);
        pa(10, 36);
        chk("a_fresh_period", period_out_a, 32'd36);
        chk("a_fresh_valid2", 32'(period_valid_a), 32'd1);

        repeat (5) @(negedge clock);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
